// File: rtl/smi_rx_stream_ctrl.sv
// SMI read-path controller: drains per-channel RX FIFOs and serialises words into SMI beats.
// Optional macro SMI_RX_MSB_FIRST_EN selects MSB-first beat order (default LSB-first).
module smi_rx_stream_ctrl #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SMI_W   = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter logic [7:0]  VERSION = 8'h02
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset_n,
  input  logic [4:0]               i_ioc,
  input  logic                     i_cs,
  input  logic                     i_fetch_cmd,
  output logic [7:0]               o_data_out,
  output logic [NUM_CH-1:0]        o_fifo_pull,
  input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
  input  logic [NUM_CH-1:0]        i_fifo_full,
  input  logic [NUM_CH-1:0]        i_fifo_empty,
  input  logic [ADDR_W-1:0]        i_smi_a,
  input  logic                     i_smi_soe_se,
  output logic [SMI_W-1:0]         o_smi_data_out,
  output logic                     o_smi_read_req,
  output logic                     o_smi_writing
);

  localparam int unsigned BPW   = WORD_W / SMI_W;
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_VALID} state_e;

  logic [2:0]              soe_q;
  logic                    soe_rise;
  logic [NUM_CH-1:0]       valid_vec;
  logic [NUM_CH-1:0]       udr_ch;
  logic [NUM_CH*SMI_W-1:0] beat_flat;
  logic [3:0]              udr_set;
  logic                    addr_set;
  logic [3:0]              err_udr_q;
  logic                    err_addr_q;
  logic [7:0]              status;
  logic [SMI_W-1:0]        smi_d;
  logic                    ioc_read;

  // Shifter resets to idle-high so release from reset is not seen as a strobe edge.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) soe_q <= '1;
    else            soe_q <= {soe_q[1:0], i_smi_soe_se};
  end

  assign soe_rise = (soe_q[2:1] == 2'b01);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e             state_q;
    logic [WORD_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx_q;
    logic               pull_q;
    logic               sel;
    logic [SMI_W-1:0]   beat;
    int unsigned        sh;

    assign sel = (i_smi_a == ADDR_W'(k));

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state_q <= ST_IDLE;
        word_q  <= '0;
        idx_q   <= '0;
        pull_q  <= 1'b0;
      end else begin
        pull_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (!i_fifo_empty[k]) begin
              pull_q  <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            word_q  <= i_fifo_data[k*WORD_W +: WORD_W];
            idx_q   <= '0;
            state_q <= ST_VALID;
          end
          ST_VALID: begin
            if (soe_rise && sel) begin
              if (idx_q == IDX_W'(BPW - 1)) begin
                idx_q   <= '0;
                state_q <= ST_IDLE;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    always_comb begin
`ifdef SMI_RX_MSB_FIRST_EN
      sh = (BPW - 1 - int'(idx_q)) * SMI_W;
`else
      sh = int'(idx_q) * SMI_W;
`endif
      beat = SMI_W'(word_q >> sh);
    end

    assign o_fifo_pull[k]                  = pull_q;
    assign valid_vec[k]                    = (state_q == ST_VALID);
    assign udr_ch[k]                       = soe_rise && sel && (state_q != ST_VALID);
    assign beat_flat[k*SMI_W +: SMI_W]     = beat;
  end

  always_comb begin
    smi_d   = '0;
    udr_set = '0;
    status  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (valid_vec[k] && (i_smi_a == ADDR_W'(k)))
        smi_d = beat_flat[k*SMI_W +: SMI_W];
      udr_set[k]      = udr_ch[k];
      status[2*k]     = i_fifo_empty[k];
      status[2*k + 1] = i_fifo_full[k];
    end
  end

  assign addr_set = soe_rise && ((i_smi_a >= ADDR_W'(NUM_CH)) || i_smi_a[ADDR_W-1]);
  assign ioc_read = i_cs && i_fetch_cmd;

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_smi_data_out <= '0;
    else            o_smi_data_out <= smi_d;
  end

  // Read-clear drops old flags but keeps any set arriving in the same cycle.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_udr_q  <= '0;
      err_addr_q <= 1'b0;
    end else if (ioc_read && (i_ioc == 5'h02)) begin
      err_udr_q  <= udr_set;
      err_addr_q <= addr_set;
    end else begin
      err_udr_q  <= err_udr_q | udr_set;
      err_addr_q <= err_addr_q | addr_set;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data_out <= '0;
    end else if (ioc_read) begin
      case (i_ioc)
        5'h00:   o_data_out <= VERSION;
        5'h01:   o_data_out <= status;
        5'h02:   o_data_out <= {err_addr_q, 3'b000, err_udr_q};
        default: o_data_out <= o_data_out;
      endcase
    end
  end

  assign o_smi_read_req = |(valid_vec | ~i_fifo_empty);
  assign o_smi_writing  = i_smi_a[ADDR_W-1];

endmodule
